// File: rtl/vc_wrr_scheduler.sv
// Two-VC weighted round-robin scheduler. It pops first-word-fall-through VC FIFOs
// and forwards each popped word to destination FIFO D0 or D1 one cycle later.
module vc_wrr_scheduler #(
  parameter int BW = 6,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          init,
  input  logic [CW-1:0] Peso_VC0,
  input  logic [CW-1:0] Peso_VC1,
  input  logic          VC0_empty,
  input  logic          VC1_empty,
  input  logic [BW-1:0] VC0_data_out,
  input  logic [BW-1:0] VC1_data_out,
  input  logic          D0_almost_full,
  input  logic          D1_almost_full,
  output logic          VC0_rd,
  output logic          VC1_rd,
  output logic          D0_wr,
  output logic          D1_wr,
  output logic [BW-1:0] D_data_in,
  output logic          active_out,
  output logic          idle_out
);

  typedef enum logic [1:0] {IDLE, SERVE0, SERVE1} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [CW-1:0] w0_reg, w1_reg;
  logic          last_reg, last_next;   // 1 = VC1 was served last
  logic          pop0, pop1;
  logic          d0_wr_reg, d1_wr_reg, active_reg, idle_reg;
  logic [BW-1:0] data_reg;

  logic [1:0]    vc_empty, elig, head_dest;
  logic [BW-1:0] head [2];

  assign vc_empty = {VC1_empty, VC0_empty};
  assign head[0]  = VC0_data_out;
  assign head[1]  = VC1_data_out;

  // A VC is eligible only if its head word's destination can still take a push.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_elig
      assign head_dest[gi] = head[gi][BW-2];
      assign elig[gi] = !vc_empty[gi] &&
                        !(head_dest[gi] ? D1_almost_full : D0_almost_full);
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    last_next  = last_reg;
    pop0       = 1'b0;
    pop1       = 1'b0;
    if (reset || init) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        SERVE0: begin
          if (elig[0] && cnt_reg < w0_reg) begin
            pop0     = 1'b1;
            cnt_next = cnt_reg + CW'(1);
          end else if (elig[1]) begin
            pop1       = 1'b1;
            state_next = SERVE1;
            cnt_next   = CW'(1);
          end else if (elig[0]) begin
            pop0     = 1'b1;
            cnt_next = w0_reg;
          end else begin
            state_next = IDLE;
            cnt_next   = '0;
          end
        end
        SERVE1: begin
          if (elig[1] && cnt_reg < w1_reg) begin
            pop1     = 1'b1;
            cnt_next = cnt_reg + CW'(1);
          end else if (elig[0]) begin
            pop0       = 1'b1;
            state_next = SERVE0;
            cnt_next   = CW'(1);
          end else if (elig[1]) begin
            pop1     = 1'b1;
            cnt_next = w1_reg;
          end else begin
            state_next = IDLE;
            cnt_next   = '0;
          end
        end
        default: begin
          if (elig[0] && (!elig[1] || last_reg)) begin
            pop0       = 1'b1;
            state_next = SERVE0;
            cnt_next   = CW'(1);
          end else if (elig[1]) begin
            pop1       = 1'b1;
            state_next = SERVE1;
            cnt_next   = CW'(1);
          end else begin
            state_next = IDLE;
            cnt_next   = '0;
          end
        end
      endcase
      if (pop0) last_next = 1'b0;
      if (pop1) last_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      last_reg   <= 1'b1;
      w0_reg     <= CW'(1);
      w1_reg     <= CW'(1);
      d0_wr_reg  <= 1'b0;
      d1_wr_reg  <= 1'b0;
      data_reg   <= '0;
      active_reg <= 1'b0;
      idle_reg   <= 1'b1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      last_reg  <= last_next;
      if (init) begin
        w0_reg <= (Peso_VC0 == '0) ? CW'(1) : Peso_VC0;
        w1_reg <= (Peso_VC1 == '0) ? CW'(1) : Peso_VC1;
      end
      d0_wr_reg <= (pop0 && !head_dest[0]) || (pop1 && !head_dest[1]);
      d1_wr_reg <= (pop0 &&  head_dest[0]) || (pop1 &&  head_dest[1]);
      if (pop0)      data_reg <= VC0_data_out;
      else if (pop1) data_reg <= VC1_data_out;
      active_reg <= pop0 || pop1;
      idle_reg   <= VC0_empty && VC1_empty && !(d0_wr_reg || d1_wr_reg);
    end
  end

  // Push strobes are masked during reset so a word popped just before reset is dropped.
  assign VC0_rd     = pop0;
  assign VC1_rd     = pop1;
  assign D0_wr      = d0_wr_reg && !reset;
  assign D1_wr      = d1_wr_reg && !reset;
  assign D_data_in  = data_reg;
  assign active_out = active_reg;
  assign idle_out   = idle_reg;

endmodule
